// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: bypass-select encoding, FSM states
// and register-index width derivation.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_FILE   = 2'b00,
        FWD_EX     = 2'b01,
        FWD_MM_PRO = 2'b10,
        FWD_MM_MEM = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_MEM_WAIT = 2'd2,
        HZ_SB_WAIT  = 2'd3
    } hz_state_t;

    // A single-register file still needs a 1-bit index.
    function automatic int reg_idx_w(input int reg_num);
        return (reg_num > 1) ? $clog2(reg_num) : 1;
    endfunction

    localparam int REG_IDX_W = reg_idx_w(32);

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy-bit array for long-latency destinations; a same-cycle set and clear
// of one register leaves the bit set.
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_NUM = 32,
    localparam int IDX_W  = reg_idx_w(REG_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en,
    input  logic [IDX_W-1:0]   set_idx,
    input  logic               clr_en,
    input  logic [IDX_W-1:0]   clr_idx,
    output logic [REG_NUM-1:0] busy
);

    logic [REG_NUM-1:0] busy_reg;

    generate
        for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (rst) begin
                    busy_reg[gi] <= 1'b0;
                end else if (set_en && (set_idx == IDX_W'(gi))) begin
                    busy_reg[gi] <= 1'b1;
                end else if (clr_en && (clr_idx == IDX_W'(gi))) begin
                    busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign busy = busy_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: bypass selects, load-use / memory-wait /
// scoreboard stalls. Optional stall counter port under HAZARD_PERF_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_NUM   = 32,
    parameter int CNT_WIDTH = 32,
    localparam int IDX_W    = reg_idx_w(REG_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 id_we,
    input  logic [IDX_W-1:0]     id_rs1,
    input  logic [IDX_W-1:0]     id_rs2,
    input  logic [IDX_W-1:0]     id_rd,
    input  logic                 ex_valid,
    input  logic                 ex_we,
    input  logic                 ex_is_load,
    input  logic                 ex_is_long,
    input  logic [IDX_W-1:0]     ex_rd,
    input  logic                 mm_valid,
    input  logic                 mm_we,
    input  logic                 mm_is_load,
    input  logic                 mm_data_ready,
    input  logic [IDX_W-1:0]     mm_rd,
    input  logic                 lu_wb_valid,
    input  logic [IDX_W-1:0]     lu_wb_rd,
    output logic [1:0]           fwd_sel_rs1,
    output logic [1:0]           fwd_sel_rs2,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 bubble_ex,
    output logic [REG_NUM-1:0]   sb_busy,
    output logic [1:0]           hz_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cycles
`endif
);

    logic      live_rs1;
    logic      live_rs2;
    logic      ex_alu;
    logic      ex_pending;
    logic      mm_pro;
    logic      mm_mem;
    logic      mm_wait;
    logic      hz_load_use;
    logic      hz_mem_wait;
    logic      hz_sb;
    logic      stall;
    logic      sb_set;
    fwd_sel_t  fwd_rs1;
    fwd_sel_t  fwd_rs2;
    hz_state_t hz_state_reg;

    assign live_rs1 = id_valid && id_uses_rs1 && (id_rs1 != '0);
    assign live_rs2 = id_valid && id_uses_rs2 && (id_rs2 != '0);

    assign ex_alu     = ex_valid && ex_we && !ex_is_load && !ex_is_long;
    assign ex_pending = ex_valid && ex_we && (ex_is_load || ex_is_long);
    assign mm_pro     = mm_valid && mm_we && !mm_is_load;
    assign mm_mem     = mm_valid && mm_we && mm_is_load && mm_data_ready;
    assign mm_wait    = mm_valid && mm_we && mm_is_load && !mm_data_ready;

    function automatic fwd_sel_t pick_fwd(input logic live, input logic [IDX_W-1:0] rs);
        fwd_sel_t sel;
        sel = FWD_FILE;
        if (live) begin
            if (ex_alu && (rs == ex_rd))
                sel = FWD_EX;
            else if (mm_pro && (rs == mm_rd))
                sel = FWD_MM_PRO;
            else if (mm_mem && (rs == mm_rd))
                sel = FWD_MM_MEM;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_rs1 = pick_fwd(live_rs1, id_rs1);
        fwd_rs2 = pick_fwd(live_rs2, id_rs2);
    end

    assign fwd_sel_rs1 = fwd_rs1;
    assign fwd_sel_rs2 = fwd_rs2;

    assign hz_load_use = (live_rs1 && ex_pending && (id_rs1 == ex_rd)) ||
                         (live_rs2 && ex_pending && (id_rs2 == ex_rd));
    assign hz_mem_wait = (live_rs1 && mm_wait && (id_rs1 == mm_rd)) ||
                         (live_rs2 && mm_wait && (id_rs2 == mm_rd));
    // Busy bits hold through the completion cycle; the RF is readable the cycle after.
    assign hz_sb       = (live_rs1 && sb_busy[id_rs1]) ||
                         (live_rs2 && sb_busy[id_rs2]) ||
                         (id_valid && id_we && sb_busy[id_rd]);

    assign stall     = hz_load_use || hz_mem_wait || hz_sb;
    assign stall_if  = stall;
    assign stall_id  = stall;
    assign bubble_ex = stall;

    assign sb_set = ex_valid && ex_we && ex_is_long && (ex_rd != '0);

    hazard_scoreboard #(
        .REG_NUM (REG_NUM)
    ) u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (sb_set),
        .set_idx (ex_rd),
        .clr_en  (lu_wb_valid),
        .clr_idx (lu_wb_rd),
        .busy    (sb_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hz_state_reg <= HZ_RUN;
        end else if (hz_load_use) begin
            hz_state_reg <= HZ_LOAD_USE;
        end else if (hz_mem_wait) begin
            hz_state_reg <= HZ_MEM_WAIT;
        end else if (hz_sb) begin
            hz_state_reg <= HZ_SB_WAIT;
        end else begin
            hz_state_reg <= HZ_RUN;
        end
    end

    assign hz_state = hz_state_reg;

`ifdef HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cycles_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_reg <= '0;
        end else if (stall && (stall_cycles_reg != '1)) begin
            stall_cycles_reg <= stall_cycles_reg + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the per-operand select of the rs1/rs2 bypass muxes in the decode stage and sequences stalls and bubbles. It tracks load-use and memory-wait hazards from the EX/MM stages and keeps a register scoreboard for multi-cycle (long-latency) units. It sits beside the ID stage and feeds `stall_if`/`stall_id`/`bubble_ex` to the pipeline registers.

## Interface
- `REG_NUM`, 32: architectural registers; index width is `$clog2(REG_NUM)`.
- `CNT_WIDTH`, 32: width of the stall performance counter.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `id_valid`, `id_uses_rs1`, `id_uses_rs2`, `id_we`  in  1 each  ID qualifiers.
- `id_rs1`, `id_rs2`, `id_rd`  in  idx  ID register indices.
- `ex_valid`, `ex_we`, `ex_is_load`, `ex_is_long`  in  1 each  EX qualifiers; `ex_is_long` means the op goes to a multi-cycle unit.
- `ex_rd`  in  idx  EX destination register.
- `mm_valid`, `mm_we`, `mm_is_load`, `mm_data_ready`  in  1 each  MM qualifiers; `mm_data_ready` means load data is valid on `mm_mem`.
- `mm_rd`  in  idx  MM destination register.
- `lu_wb_valid`  in  1  long-unit completion (RF write this cycle).
- `lu_wb_rd`  in  idx  long-unit destination.
- `fwd_sel_rs1`, `fwd_sel_rs2`  out  2  mux select: 00 file_out, 01 ex_pro, 10 mm_pro, 11 mm_mem.
- `stall_if`, `stall_id`  out  1  hold PC and the IF/ID register.
- `bubble_ex`  out  1  insert a NOP into ID/EX.
- `sb_busy`  out  REG_NUM  scoreboard bits.
- `hz_state`  out  2  registered FSM state.
- `stall_cycles`  out  CNT_WIDTH  present only with `HAZARD_PERF_EN`.

## Operation
- An operand is "live" when `id_valid`, its use bit is set, and its index is non-zero. Register x0 never forwards, never stalls, and is never set in the scoreboard.
- Forward priority per live operand (first match wins):
  - EX match with `ex_valid & ex_we & !ex_is_load & !ex_is_long` gives 01.
  - MM match with `mm_valid & mm_we & !mm_is_load` gives 10.
  - MM match with `mm_valid & mm_we & mm_is_load & mm_data_ready` gives 11.
  - Otherwise 00.
- Hazard conditions (any one asserts `stall_if = stall_id = bubble_ex = 1`):
  - LOAD_USE: a live operand matches EX with `ex_valid & ex_we & (ex_is_load | ex_is_long)`.
  - MEM_WAIT: a live operand matches MM with `mm_valid & mm_we & mm_is_load & !mm_data_ready`.
  - SB: a live operand has `sb_busy` set, or `id_valid & id_we & sb_busy[id_rd]` (WAW).
- Stall outputs are combinational from current inputs and `sb_busy`.
- FSM states RUN=0, LOAD_USE=1, MEM_WAIT=2, SB_WAIT=3. The next state is the highest-priority active hazard (LOAD_USE > MEM_WAIT > SB), or RUN if none. The state is registered every cycle and is debug/perf only; it never gates the outputs.
- Scoreboard:
  - Set `sb_busy[ex_rd]` at the edge when `ex_valid & ex_we & ex_is_long & ex_rd != 0`.
  - Clear `sb_busy[lu_wb_rd]` when `lu_wb_valid`.
  - If set and clear target the same register in one cycle, set wins.
  - A clear of an already-clear bit is ignored.
- While `sb_busy[r]` is set, an operand reading r stalls even during the completion cycle. Release happens the cycle after `lu_wb_valid`, when the RF holds the value.

## Timing
- Forward selects and stalls are combinational, 0-cycle latency, and valid the same cycle.
- Scoreboard and FSM update on the rising edge; the scoreboard-driven stall drops exactly 1 cycle after `lu_wb_valid`.
- Reset values: `sb_busy = 0`, `hz_state = RUN`, `stall_cycles = 0`. Combinational outputs follow the inputs, so with all valids low: selects 00, stalls 0.
- Reset mid-operation clears all busy bits immediately at the edge. In-flight long ops are the pipeline's responsibility to flush.
- Load-use gives exactly 1 bubble when the load data is ready in MM on the next cycle; each further `!mm_data_ready` cycle adds one stall.

## Configuration
- `HAZARD_PERF_EN` defined: the `stall_cycles` port exists and increments by 1 every cycle `stall_id` = 1. It saturates at all-ones and resets to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- The shared package holds:
  - `fwd_sel_t` enum (FWD_FILE=2'b00, FWD_EX=2'b01, FWD_MM_PRO=2'b10, FWD_MM_MEM=2'b11).
  - `hz_state_t` enum.
  - `REG_IDX_W` derivation.
- Natural sub-module: `hazard_scoreboard` (busy-bit array with set/clear ports and priority rule). The forwarding and stall logic stays in `hazard_ctrl`.

## Test plan
- ID rs1=5, EX ALU rd=5 we=1: `fwd_sel_rs1 = 01`, no stall. With rs1=0 and EX rd=0: `fwd_sel_rs1 = 00`.
- ID rs2=7, EX load rd=7: one cycle `stall_id = bubble_ex = 1`, `hz_state` goes to LOAD_USE. Next cycle, MM load rd=7 with `mm_data_ready = 1`: `fwd_sel_rs2 = 11`, stall 0.
- MM load rd=3 with `mm_data_ready` low for 3 cycles, ID rs1=3: stall 3 cycles with `hz_state` = MEM_WAIT. Select 11 on the ready cycle.
- EX long rd=9 issued:
  - `sb_busy[9] = 1` next cycle.
  - ID rs1=9 stalls until the cycle after `lu_wb_valid` with rd=9.
  - ID `id_we`=1 with `id_rd`=9 also stalls (WAW).
- Same-cycle EX long rd=4 and `lu_wb_valid` rd=4 with bit set: `sb_busy[4]` stays 1. Assert `rst` for 1 cycle with bits 4 and 9 set: all bits 0 next cycle.
- `HAZARD_PERF_EN` build: 5 stall cycles raise `stall_cycles` from 0 to 5. Preload near all-ones: the counter saturates and does not wrap.
